// File: rtl/mmio_arbiter_pkg.sv
// Shared definitions for the MMIO arbiter: FSM state codes and the
// peripheral address map used by the LED/SW/SEG decoder.
package mmio_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] ADDR_LED = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_SEG = 32'hFFFF_0008;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way combinational round-robin picker: on a tie the master that
// did not own the bus last wins.
module rr_arb2
    import mmio_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = onehot2(~last);
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares the MMIO decoder port between M0 (CPU) and M1 (UART loader) with
// round-robin arbitration and per-master lock. Define MMIO_ARB_TIMEOUT_EN to
// bound consecutive locked grants to LOCK_MAX.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    input  logic          m0_we,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    input  logic          m1_we,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wd,
    output logic          we,
    input  logic [DW-1:0] rd,
    output logic [1:0]    grant
);

    if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_lock_max_range
        $error("LOCK_MAX must lie in 1..255 to fit the 8-bit lock counter");
    end

    arb_state_t    state_reg;
    logic          owner_reg;
    logic          last_reg;
    logic [1:0]    grant_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wd_reg;
    logic          we_reg;
    logic [1:0]    ack_reg;
    logic [DW-1:0] rd_reg [2];

    logic [1:0]    req_vec;
    logic [1:0]    lock_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec [2];
    logic [DW-1:0] wd_vec [2];
    logic [1:0]    pick_gnt;
    logic          sel;
    logic          lock_ok;
    logic          regrant;

    assign req_vec     = {m1_req, m0_req};
    assign lock_vec    = {m1_lock, m0_lock};
    assign we_vec      = {m1_we, m0_we};
    assign addr_vec[0] = m0_addr;
    assign addr_vec[1] = m1_addr;
    assign wd_vec[0]   = m0_wd;
    assign wd_vec[1]   = m1_wd;

    rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (last_reg),
        .gnt  (pick_gnt)
    );

    // A fresh grant comes from the picker; a locked re-grant keeps the owner.
    assign sel     = (state_reg == IDLE) ? pick_gnt[1] : owner_reg;
    assign regrant = lock_vec[owner_reg] & req_vec[owner_reg] & lock_ok;

`ifdef MMIO_ARB_TIMEOUT_EN
    logic [7:0] lock_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            lock_cnt_reg <= '0;
        end else if (state_reg == RESP && regrant) begin
            lock_cnt_reg <= lock_cnt_reg + 8'd1;
        end
    end

    assign lock_ok = (lock_cnt_reg != 8'(LOCK_MAX));
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            grant_reg <= 2'b00;
            addr_reg  <= '0;
            wd_reg    <= '0;
            we_reg    <= 1'b0;
            ack_reg   <= 2'b00;
            rd_reg[0] <= '0;
            rd_reg[1] <= '0;
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        owner_reg <= sel;
                        last_reg  <= sel;
                        grant_reg <= pick_gnt;
                        addr_reg  <= addr_vec[sel];
                        wd_reg    <= wd_vec[sel];
                        we_reg    <= we_vec[sel];
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    rd_reg[owner_reg]  <= rd;
                    ack_reg[owner_reg] <= 1'b1;
                    we_reg             <= 1'b0;
                    state_reg          <= RESP;
                end
                RESP: begin
                    if (regrant) begin
                        addr_reg  <= addr_vec[sel];
                        wd_reg    <= wd_vec[sel];
                        we_reg    <= we_vec[sel];
                        state_reg <= XFER;
                    end else begin
                        addr_reg  <= '0;
                        wd_reg    <= '0;
                        grant_reg <= 2'b00;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    grant_reg <= 2'b00;
                    we_reg    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign addr   = addr_reg;
    assign wd     = wd_reg;
    assign we     = we_reg;
    assign grant  = grant_reg;
    assign m0_ack = ack_reg[0];
    assign m1_ack = ack_reg[1];
    assign m0_rd  = rd_reg[0];
    assign m1_rd  = rd_reg[1];

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: stimulus pushes the expected service
// order; a negedge monitor checks each ACK against the preceding XFER cycle.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int LM = 2;
`else
    localparam int LM = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wd = '0;
    logic        m0_ack;
    logic [31:0] m0_rd;
    logic        m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wd = '0;
    logic        m1_ack;
    logic [31:0] m1_rd;
    logic [31:0] addr_bus, wd_bus, rd_bus;
    logic        we_bus;
    logic [1:0]  grant;
    logic [31:0] sw_val = 32'h0000_00A5;

    always #5 clk = ~clk;

    // Decoder model: switches readable, everything else reads 0.
    assign rd_bus = (addr_bus == ADDR_SW) ? sw_val : 32'h0;

    mmio_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_we(m0_we), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_we(m1_we), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .addr(addr_bus), .wd(wd_bus), .we(we_bus), .rd(rd_bus), .grant(grant)
    );

    typedef struct {
        int          m;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [31:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic push(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] r);
        exp_t e;
        e.m = m; e.a = a; e.d = d; e.w = w; e.r = r;
        exp_q.push_back(e);
    endtask

    // Monitor: values seen one negedge earlier belong to the XFER cycle.
    logic [1:0]  prev_grant = '0;
    logic [31:0] prev_addr = '0, prev_wd = '0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack)) begin
            exp_t e;
            int   am;
            am = m1_ack ? 1 : 0;
            if (m0_ack && m1_ack) begin
                chk("ack_both", {m1_ack, m0_ack}, 2'b01);
            end else if (exp_q.size() == 0) begin
                chk("ack_unexpected", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_master", am, e.m);
                chk("xfer_grant", {30'd0, prev_grant}, (e.m == 0) ? 32'd1 : 32'd2);
                chk("xfer_addr", prev_addr, e.a);
                chk("xfer_wd", prev_wd, e.d);
                chk("xfer_we", {31'd0, prev_we}, {31'd0, e.w});
                chk("ack_rd", am ? m1_rd : m0_rd, e.r);
                chk("resp_we_low", {31'd0, we_bus}, 32'd0);
                $display("txn m%0d addr=%h wd=%h we=%0d rd=%h", am, prev_addr, prev_wd,
                         prev_we, am ? m1_rd : m0_rd);
            end
        end
        prev_grant <= grant;
        prev_addr  <= addr_bus;
        prev_wd    <= wd_bus;
        prev_we    <= we_bus;
    end

    task automatic access(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic lk, input logic keep, output int waited);
        logic got;
        waited = 0;
        got = 1'b0;
        if (m == 0) begin
            m0_req = 1'b1; m0_lock = lk; m0_addr = a; m0_wd = d; m0_we = w;
        end else begin
            m1_req = 1'b1; m1_lock = lk; m1_addr = a; m1_wd = d; m1_we = w;
        end
        while (!got && waited < 40) begin
            @(negedge clk);
            waited++;
            got = (m == 0) ? m0_ack : m1_ack;
        end
        chk($sformatf("m%0d_ack_seen", m), {31'd0, got}, 32'd1);
        if (!keep) begin
            if (m == 0) begin m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0; end
            else        begin m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int wt, wt0, wt1;
        int spin;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_we", {31'd0, we_bus}, 32'd0);
        chk("rst_addr", addr_bus, 32'd0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: M0 reads switches alone, ACK two cycles after REQ
        push(0, ADDR_SW, 32'h0, 1'b0, 32'h0000_00A5);
        access(0, ADDR_SW, 32'h0, 1'b0, 1'b0, 1'b0, wt);
        chk("t1_latency", wt, 2);

        // 2: simultaneous writes from reset: M0 first, then M1
        do_reset();
        push(0, ADDR_LED, 32'h1234, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'h5678, 1'b1, 32'h0);
        fork
            access(0, ADDR_LED, 32'h1234, 1'b1, 1'b0, 1'b0, wt0);
            access(1, ADDR_SEG, 32'h5678, 1'b1, 1'b0, 1'b0, wt1);
        join
        @(negedge clk);
        chk("t2_idle_grant", {30'd0, grant}, 32'd0);
        chk("t2_idle_addr", addr_bus, 32'd0);

        // 3: both stream 4 unlocked requests -> strict alternation from M0
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(0, ADDR_SW, 32'h0, 1'b0, 32'h0000_00A5);
            else            push(0, ADDR_LED, 32'h10 + i, 1'b1, 32'h0);
            if (i % 2 == 0) push(1, 32'h100 + i, 32'h0, 1'b0, 32'h0);
            else            push(1, ADDR_SEG, 32'h20 + i, 1'b1, 32'h0);
        end
        fork
            for (int i = 0; i < 4; i++) begin
                int w0;
                if (i % 2 == 0) access(0, ADDR_SW, 32'h0, 1'b0, 1'b0, (i < 3), w0);
                else            access(0, ADDR_LED, 32'h10 + i, 1'b1, 1'b0, (i < 3), w0);
            end
            for (int j = 0; j < 4; j++) begin
                int w1;
                if (j % 2 == 0) access(1, 32'h100 + j, 32'h0, 1'b0, 1'b0, (j < 3), w1);
                else            access(1, ADDR_SEG, 32'h20 + j, 1'b1, 1'b0, (j < 3), w1);
            end
        join
        @(negedge clk);

        // 4: M1 locked burst of 3 writes while M0 waits
        push(1, ADDR_SEG, 32'hA1, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'hA2, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'hA3, 1'b1, 32'h0);
        push(0, ADDR_LED, 32'hB0, 1'b1, 32'h0);
        fork
            begin
                access(1, ADDR_SEG, 32'hA1, 1'b1, 1'b1, 1'b1, wt1);
                access(1, ADDR_SEG, 32'hA2, 1'b1, 1'b1, 1'b1, wt1);
                chk("t4_lock_spacing2", wt1, 2);
                access(1, ADDR_SEG, 32'hA3, 1'b1, 1'b1, 1'b0, wt1);
                chk("t4_lock_spacing3", wt1, 2);
            end
            begin
                @(negedge clk);
                access(0, ADDR_LED, 32'hB0, 1'b1, 1'b0, 1'b0, wt0);
            end
        join
        @(negedge clk);

        // 5: reset during an M0 write XFER, then reissue
        do_reset();
        m0_req = 1'b1; m0_lock = 1'b0; m0_addr = ADDR_LED; m0_wd = 32'hDEAD; m0_we = 1'b1;
        @(negedge clk);
        chk("t5_we_in_xfer", {31'd0, we_bus}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_we_async_drop", {31'd0, we_bus}, 32'd0);
        chk("t5_grant_async_drop", {30'd0, grant}, 32'd0);
        m0_req = 1'b0; m0_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(0, ADDR_LED, 32'hDEAD, 1'b1, 32'h0);
        access(0, ADDR_LED, 32'hDEAD, 1'b1, 1'b0, 1'b0, wt);
        chk("t5_reissue_latency", wt, 2);

`ifdef MMIO_ARB_TIMEOUT_EN
        // 6: lock bounded at LOCK_MAX=2 re-grants, M0 gets in after the 3rd ACK
        do_reset();
        push(1, ADDR_SEG, 32'hC1, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'hC2, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'hC3, 1'b1, 32'h0);
        push(0, ADDR_LED, 32'hD0, 1'b1, 32'h0);
        push(1, ADDR_SEG, 32'hC4, 1'b1, 32'h0);
        fork
            begin
                access(1, ADDR_SEG, 32'hC1, 1'b1, 1'b1, 1'b1, wt1);
                access(1, ADDR_SEG, 32'hC2, 1'b1, 1'b1, 1'b1, wt1);
                access(1, ADDR_SEG, 32'hC3, 1'b1, 1'b1, 1'b1, wt1);
                access(1, ADDR_SEG, 32'hC4, 1'b1, 1'b1, 1'b0, wt1);
                chk("t6_lock_broken_wait", {31'd0, (wt1 > 2)}, 32'd1);
            end
            begin
                @(negedge clk);
                access(0, ADDR_LED, 32'hD0, 1'b1, 1'b0, 1'b0, wt0);
            end
        join
`endif

        spin = 0;
        while (exp_q.size() != 0 && spin < 20) begin
            @(negedge clk);
            spin++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
